// File: rtl/cdp1802_dma.sv
// Cycle-stealing RAM arbiter with a single DMA channel moving bytes between
// RAM and a ready/valid byte stream, using only cycles the CPU leaves free.
//
// state | meaning
// IDLE  | no transfer; waiting for dma_start
// RUN   | transfer active; issuing RAM reads (dir 0) or writes (dir 1)
// DRAIN | all reads issued; waiting for in-flight byte and FIFO to empty
module cdp1802_dma #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        resetq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic [15:0] ram_a,
    output logic [7:0]  ram_d,
    input  logic [7:0]  ram_q,
    input  logic        dma_start,
    input  logic        dma_dir,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_len,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state, state_nx;
    logic [15:0]   addr, addr_nx;
    logic [15:0]   remaining, remaining_nx;
    logic          dir, dir_nx;
    logic          done_nx;
    logic          in_flight;
    logic [7:0]    fifo [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, occ;
    logic          free, dma_rd, dma_wr, pop, push;

    assign free = !cpu_rd && !cpu_wr;
    assign pop  = (count != '0) && out_ready;
    assign push = in_flight;
    // Credit the same-cycle pop so a full-rate stream keeps one read per cycle.
    assign occ  = count + CW'(in_flight) - CW'(pop);

    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        remaining_nx = remaining;
        dir_nx       = dir;
        done_nx      = 1'b0;
        dma_rd       = 1'b0;
        dma_wr       = 1'b0;
        in_ready     = 1'b0;
        case (state)
            S_IDLE: begin
                if (dma_start) begin
                    if (dma_len != 16'd0) begin
                        addr_nx      = dma_addr;
                        remaining_nx = dma_len;
                        dir_nx       = dma_dir;
                        state_nx     = S_RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!dir) begin
                    if (free && remaining != 16'd0 && occ < CW'(DEPTH)) begin
                        dma_rd       = 1'b1;
                        addr_nx      = addr + 16'd1;
                        remaining_nx = remaining - 16'd1;
                        if (remaining == 16'd1) state_nx = S_DRAIN;
                    end
                end else begin
                    in_ready = free && remaining != 16'd0;
                    if (in_valid && in_ready) begin
                        dma_wr       = 1'b1;
                        addr_nx      = addr + 16'd1;
                        remaining_nx = remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight && count == '0) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // DMA strobes only fire on free cycles, so OR-ing keeps CPU accesses untouched.
    assign ram_rd    = cpu_rd | dma_rd;
    assign ram_wr    = cpu_wr | dma_wr;
    assign ram_a     = (dma_rd || dma_wr) ? addr : cpu_a;
    assign ram_d     = dma_wr ? in_data : cpu_d;
    assign cpu_q     = ram_q;
    assign busy      = (state != S_IDLE);
    assign out_valid = (count != '0);
    assign out_data  = fifo[rd_ptr];

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            state     <= S_IDLE;
            addr      <= 16'd0;
            remaining <= 16'd0;
            dir       <= 1'b0;
            done      <= 1'b0;
            in_flight <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            remaining <= remaining_nx;
            dir       <= dir_nx;
            done      <= done_nx;
            in_flight <= dma_rd;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr] <= ram_q;
    end
endmodule

// File: tb/tb_cdp1802_dma.sv
// Directed bench for cdp1802_dma: CPU passthrough, both transfer directions,
// backpressure, zero length, ignored restart and mid-transfer reset.
module tb_cdp1802_dma;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        resetq = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_a = '0;
    logic [7:0]  cpu_d = '0;
    logic [7:0]  cpu_q;
    logic        ram_rd, ram_wr;
    logic [15:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = '0;
    logic        dma_start = 1'b0, dma_dir = 1'b0;
    logic [15:0] dma_addr = '0, dma_len = '0;
    logic        busy, done;
    logic        out_valid, out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  in_data = '0;

    cdp1802_dma #(.DEPTH(DEPTH)) dut (
        .clock(clock), .resetq(resetq),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_addr(dma_addr), .dma_len(dma_len),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [65536];
    always @(posedge clock) begin
        if (ram_wr) mem[ram_a] <= ram_d;
        if (ram_rd) ram_q <= mem[ram_a];
    end

    int checks = 0, errors = 0, cyc = 0;
    int done_cnt = 0, dma_rd_cnt = 0, dma_wr_cnt = 0, done_busy = 0;
    logic [7:0] rx_q[$];
    int rx_t[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (resetq) begin
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rx_t.push_back(cyc);
            end
            if (done) done_cnt++;
            if (done && busy) done_busy++;
            if (ram_rd && !cpu_rd && !cpu_wr) dma_rd_cnt++;
            if (ram_wr && !cpu_wr) dma_wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_dma(input logic d, input logic [15:0] a, input logic [15:0] l);
        dma_start = 1'b1; dma_dir = d; dma_addr = a; dma_len = l;
        tick;
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        tick;
    endtask

    task automatic clear_rx;
        rx_q.delete();
        rx_t.delete();
    endtask

    int d0, r0, w0, idx;
    logic hs, prev_rd;

    initial begin
        repeat (2) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        resetq = 1'b1;
        tick;

        // CPU-only traffic while idle
        for (int i = 0; i < 16; i++) begin
            cpu_rd = 1'($urandom_range(0, 1));
            cpu_wr = 1'($urandom_range(0, 1));
            cpu_a  = 16'($urandom);
            cpu_d  = 8'($urandom);
            #1;
            chk("cpu_pass", {ram_rd, ram_wr, ram_a, ram_d}, {cpu_rd, cpu_wr, cpu_a, cpu_d});
            chk("cpu_out_valid", out_valid, 0);
            chk("cpu_in_ready", in_ready, 0);
            tick;
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick;

        // RAM -> stream, all cycles free
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
        out_ready = 1'b1;
        clear_rx();
        d0 = done_cnt; r0 = dma_rd_cnt;
        start_dma(1'b0, 16'h0100, 16'd4);
        chk("r2s_busy", busy, 1);
        wait_done(d0, 30);
        repeat (2) tick;
        chk("r2s_done_once", done_cnt, d0 + 1);
        chk("r2s_count", rx_q.size(), 4);
        chk("r2s_reads", dma_rd_cnt - r0, 4);
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("r2s_data", rx_q[i], 8'h11 * (i + 1));
            for (int i = 1; i < 4; i++) chk("r2s_consec", rx_t[i] - rx_t[i-1], 1);
        end

        // Stream -> RAM with CPU reads on alternate cycles, crossing FFFF
        mem[16'h0050] = 8'h5A;
        d0 = done_cnt; idx = 0; prev_rd = 1'b0;
        start_dma(1'b1, 16'hFFFE, 16'd3);
        for (int c = 0; c < 30 && done_cnt == d0; c++) begin
            cpu_rd   = c[0];
            cpu_a    = 16'h0050;
            in_valid = (idx < 3);
            in_data  = 8'hA0 + 8'(idx);
            #1;
            if (prev_rd) chk("s2r_cpu_q", cpu_q, 8'h5A);
            if (cpu_rd) chk("s2r_in_ready_cpu", in_ready, 0);
            hs = in_valid && in_ready;
            tick;
            if (hs) idx++;
            prev_rd = cpu_rd;
        end
        cpu_rd = 1'b0; in_valid = 1'b0;
        tick;
        chk("s2r_bytes", idx, 3);
        chk("s2r_done_once", done_cnt, d0 + 1);
        chk("s2r_mem_fffe", mem[16'hFFFE], 8'hA0);
        chk("s2r_mem_ffff", mem[16'hFFFF], 8'hA1);
        chk("s2r_mem_0000", mem[16'h0000], 8'hA2);
        chk("s2r_in_ready_idle", in_ready, 0);

        // Backpressure plus an ignored start while busy
        for (int i = 0; i < 8; i++) mem[16'h0200 + i] = 8'hC0 + 8'(i);
        out_ready = 1'b0;
        clear_rx();
        d0 = done_cnt; r0 = dma_rd_cnt; w0 = dma_wr_cnt;
        start_dma(1'b0, 16'h0200, 16'd8);
        repeat (10) tick;
        chk("bp_reads", dma_rd_cnt - r0, DEPTH);
        chk("bp_out_valid", out_valid, 1);
        start_dma(1'b1, 16'h0300, 16'd5);
        chk("bp_restart_busy", busy, 1);
        chk("bp_restart_in_ready", in_ready, 0);
        out_ready = 1'b1;
        wait_done(d0, 60);
        repeat (2) tick;
        chk("bp_done_once", done_cnt, d0 + 1);
        chk("bp_count", rx_q.size(), 8);
        chk("bp_reads_total", dma_rd_cnt - r0, 8);
        chk("bp_no_writes", dma_wr_cnt - w0, 0);
        if (rx_q.size() == 8)
            for (int i = 0; i < 8; i++) chk("bp_data", rx_q[i], 8'hC0 + 8'(i));

        // Zero-length start
        d0 = done_cnt; r0 = dma_rd_cnt; w0 = dma_wr_cnt;
        start_dma(1'b0, 16'h0400, 16'd0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        tick;
        chk("len0_done_low", done, 0);
        tick;
        chk("len0_no_rd", dma_rd_cnt - r0, 0);
        chk("len0_no_wr", dma_wr_cnt - w0, 0);
        chk("len0_done_once", done_cnt, d0 + 1);

        // Reset in the middle of a transfer
        out_ready = 1'b0;
        clear_rx();
        d0 = done_cnt;
        start_dma(1'b0, 16'h0200, 16'd8);
        repeat (3) tick;
        chk("mid_busy", busy, 1);
        resetq = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        repeat (2) tick;
        resetq = 1'b1;
        r0 = dma_rd_cnt;
        repeat (5) tick;
        chk("mid_no_done", done_cnt, d0);
        chk("mid_no_reads", dma_rd_cnt - r0, 0);
        chk("mid_idle", busy, 0);

        out_ready = 1'b1;
        clear_rx();
        d0 = done_cnt;
        start_dma(1'b0, 16'h0100, 16'd4);
        wait_done(d0, 30);
        chk("fresh_count", rx_q.size(), 4);
        if (rx_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("fresh_data", rx_q[i], 8'h11 * (i + 1));

        chk("done_busy_overlap", done_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
